// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch/lap timer: the state encoding that
// appears on the stat output, and the seconds field width and limit.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    localparam int SEC_W = 6;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    // Saturate a seconds value to the legal 0..59 range.
    function automatic logic [SEC_W-1:0] sat_secs(input logic [SEC_W-1:0] s);
        return (s > SEC_MAX) ? SEC_MAX : s;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICKS_PER_SEC cycles of run.
// Holds its count while run is low; clr (or rst) returns it to zero.
module tick_prescaler #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt;

    // Combinational so the time update lands on the same edge that wraps the count.
    assign tick = run && (cnt == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_lap_timer.sv
// Stopwatch with up/down counting, preset load, lap capture and a done pulse.
// Holds the control FSM and the time/lap datapath; the seconds prescaler is a sub-module.
module stopwatch_lap_timer
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int MIN_W         = 8,
    parameter int MAX_MIN       = 99
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             reset,
    input  logic             lap,
    input  logic             mode,
    input  logic             load_en,
    input  logic [MIN_W-1:0] load_mins,
    input  logic [SEC_W-1:0] load_secs,
    output logic [MIN_W-1:0] mins,
    output logic [SEC_W-1:0] secs,
    output logic [MIN_W-1:0] lap_mins,
    output logic [SEC_W-1:0] lap_secs,
    output logic             lap_valid,
    output logic             done,
    output logic [1:0]       stat
);

    localparam logic [MIN_W-1:0] MIN_CEIL = MIN_W'(MAX_MIN);

    state_t           state_q, state_d;
    logic             dir_q, dir_eff;
    logic [MIN_W-1:0] mins_q, mins_d, lap_mins_q;
    logic [SEC_W-1:0] secs_q, secs_d, lap_secs_q;
    logic             lap_valid_q, done_q, zero_pend_q;
    logic             tick, load_ok, time_zero, at_ceiling, terminal;
    logic             lap_take, zero_start, run, clr;

    assign run = (state_q == ST_RUNNING);
    assign clr = reset || (state_q == ST_IDLE) || (state_q == ST_DONE);

    tick_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .run (run),
        .clr (clr),
        .tick(tick)
    );

    // In IDLE the direction follows mode live, so a start sees the mode of its own edge.
    assign dir_eff    = (state_q == ST_IDLE) ? mode : dir_q;
    assign load_ok    = load_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign time_zero  = (mins_q == '0) && (secs_q == '0);
    assign at_ceiling = (mins_q == MIN_CEIL) && (secs_q == SEC_MAX);
    assign terminal   = tick && (dir_q ? ((mins_q == '0) && (secs_q == 6'd1)) : at_ceiling);
    assign lap_take   = lap && !reset && ((state_q == ST_RUNNING) || (state_q == ST_PAUSED));
    assign zero_start = (state_q == ST_IDLE) && !reset && !load_ok && start && !stop
                        && dir_eff && time_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        if (reset || load_ok) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_d = (dir_eff && time_zero) ? ST_DONE : ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (terminal) begin
                        state_d = ST_DONE;
                    end else if (stop) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (start && !stop) begin
                        state_d = ST_RUNNING;
                    end
                end
                default: state_d = ST_DONE;
            endcase
        end
    end

    always_comb begin
        mins_d = mins_q;
        secs_d = secs_q;
        if (reset) begin
            mins_d = '0;
            secs_d = '0;
        end else if (load_ok) begin
            mins_d = (load_mins > MIN_CEIL) ? MIN_CEIL : load_mins;
            secs_d = sat_secs(load_secs);
        end else if (tick) begin
            if (!dir_q) begin
                // At the ceiling the time holds; the FSM moves to DONE instead.
                if (!at_ceiling) begin
                    if (secs_q == SEC_MAX) begin
                        secs_d = '0;
                        mins_d = mins_q + 1'b1;
                    end else begin
                        secs_d = secs_q + 1'b1;
                    end
                end
            end else if (secs_q != '0) begin
                secs_d = secs_q - 1'b1;
            end else if (mins_q != '0) begin
                secs_d = SEC_MAX;
                mins_d = mins_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mins_q      <= '0;
            secs_q      <= '0;
            lap_mins_q  <= '0;
            lap_secs_q  <= '0;
            lap_valid_q <= 1'b0;
            done_q      <= 1'b0;
            zero_pend_q <= 1'b0;
            dir_q       <= 1'b0;
        end else begin
            mins_q <= mins_d;
            secs_q <= secs_d;
            if (state_q == ST_IDLE) begin
                dir_q <= mode;
            end
            if (reset) begin
                lap_mins_q <= '0;
                lap_secs_q <= '0;
            end else if (lap_take) begin
                lap_mins_q <= mins_q;
                lap_secs_q <= secs_q;
            end
            lap_valid_q <= lap_take;
            // A start at 00:00 counting down reports done one cycle after entering DONE.
            zero_pend_q <= zero_start;
            done_q      <= !reset && (terminal || zero_pend_q);
        end
    end

    assign mins      = mins_q;
    assign secs      = secs_q;
    assign lap_mins  = lap_mins_q;
    assign lap_secs  = lap_secs_q;
    assign lap_valid = lap_valid_q;
    assign done      = done_q;
    assign stat      = state_q;

endmodule
